ofifo: RTL and testbench
========================

OFIFO -- requirements
Module: ofifo

Interface
REQ-001: Parameter col, default 8, number of array columns captured.
REQ-002: Parameter psum_bw, default 16, width of one partial sum.
REQ-003: Parameter depth, default 16, entries per column; power of two, at least 2.
REQ-004: clk  input  1  single clock, all state on rising edge.
REQ-005: reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-006: in  input  col*psum_bw  column psums from the array's south outputs; column k at bits [(k+1)*psum_bw-1 : k*psum_bw].
REQ-007: wr  input  col  per-column write strobe; wr[k]=1 pushes column k of in.
REQ-008: rd  input  1  pop request for one full row.
REQ-009: out  output  col*psum_bw  head entry of every column, same column packing as in.
REQ-010: o_valid  output  1  every column is non-empty.
REQ-011: o_full  output  1  at least one column is full.
REQ-012: o_ready  output  1  no column is full; equals ~o_full.

Function
REQ-013: Each column is an independent circular FIFO of depth entries.
- Write pointer and read pointer are log2(depth)+1 bits wide.
- Empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
REQ-014: wr[k]=1 on a non-full column k writes in[k] at the write pointer and increments it, wrapping modulo 2*depth.
REQ-015: wr[k]=1 on a full column drops the data unless the same cycle performs an accepted pop; in that case both the write and the pop take effect.
REQ-016: An accepted pop is rd=1 while o_valid=1.
- It increments every column's read pointer in the same cycle.
- rd=1 while o_valid=0 is ignored with no state change.
REQ-017: out is first-word-fall-through: combinational from each column's head entry, valid in the same cycle o_valid is 1.
REQ-018: out is don't-care while o_valid=0.
REQ-019: A write to an empty column is visible at out, and contributes to o_valid, one cycle after the write edge.
REQ-020: Columns may be written in different cycles; row alignment comes from per-column order only.
REQ-021: o_valid, o_full and o_ready are combinational decodes of the registered pointers.
REQ-022: Data is stored unmodified; no arithmetic is performed on psums.

Reset
REQ-023: While reset=0, all pointers are 0 and the outputs are o_valid=0, o_full=0, o_ready=1.
REQ-024: Reset mid-operation discards all stored entries; storage contents need not be cleared.
REQ-025: The first rising edge after reset returns to 1 may accept writes.

Configuration
REQ-026: With OFIFO_OVERFLOW_FLAG_EN defined, the block adds output o_overflow (1 bit).
- o_overflow is sticky and set on any dropped write (REQ-015).
- It is cleared only by reset; its reset value is 0.
REQ-027: Without OFIFO_OVERFLOW_FLAG_EN, the o_overflow port and its logic are absent; dropped writes are silent.

Structure
REQ-028: A shared package/header holds the default constants PSUM_BW=16, COL=8, OFIFO_DEPTH=16 and the pointer-width function clog2.
REQ-029: One sub-module, ofifo_col, implements a single-column FIFO with ports clk, reset, wr, rd, in, out, empty, full.
REQ-030: ofifo instantiates col copies of ofifo_col and derives o_valid, o_full and o_ready by reduction over the columns.

Verification
REQ-031: Reset (reset=0) with wr=all ones held -> o_valid=0, o_full=0, o_ready=1; no entry is stored after release without new writes.
REQ-032: col=8; write rows 0x0001..0x0004 to all columns in 4 cycles, then hold rd=1 -> out column 0 reads 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles; o_valid falls after the 4th pop.
REQ-033: Staggered writes: wr=8'h01 at t0, 8'h02 at t1, ..., 8'h80 at t7 -> o_valid=0 through t7 and 1 from t8; out holds each column's value.
REQ-034: Fill column 3 with 16 writes -> o_full=1, o_ready=0; a 17th write with rd=0 is dropped (o_overflow=1 when enabled); a 17th write with an accepted pop is kept and o_full stays 1.
REQ-035: 40 write/pop pairs on all columns (crosses the pointer wrap) -> data order preserved with no false full/empty.
REQ-036: reset asserted asynchronously mid-burst with 5 entries stored -> o_valid drops to 0 without a clock edge; o_valid stays 0 after release.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the output FIFO that collects psums from the array.
package ofifo_pkg;

  localparam int PSUM_BW     = 16;
  localparam int COL         = 8;
  localparam int OFIFO_DEPTH = 16;

  // Ceiling log2, used to size pointers; the pointers carry one extra wrap bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ofifo_col.sv
// One column of the output FIFO: a circular buffer with wrap-bit pointers.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] in,
  output logic [psum_bw-1:0] out,
  output logic               empty,
  output logic               full
);

  localparam int aw = clog2(depth);

  logic [psum_bw-1:0] mem [depth];
  logic [aw:0]        wr_ptr;
  logic [aw:0]        rd_ptr;
  logic               do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);

  // A full column still accepts a write when the same edge frees the head slot.
  assign do_wr = wr && (!full || rd);
  assign out   = mem[rd_ptr[aw-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[aw-1:0]] <= in;
  end

endmodule

// File: rtl/ofifo.sv
// Output FIFO: col independent column FIFOs popped together as one row.
// Define OFIFO_OVERFLOW_FLAG_EN to add the sticky o_overflow output.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
`ifdef OFIFO_OVERFLOW_FLAG_EN
  output logic                   o_overflow,
`endif
  output logic                   o_ready
);

  logic [col-1:0] empty_vec;
  logic [col-1:0] full_vec;
  logic           pop;

  // A row pop is only honoured when every column has a head entry.
  assign pop     = rd && o_valid;
  assign o_valid = ~|empty_vec;
  assign o_full  = |full_vec;
  assign o_ready = ~o_full;

  for (genvar k = 0; k < col; k++) begin : g_col
    ofifo_col #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_col (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[k]),
      .rd   (pop),
      .in   (in[k*psum_bw +: psum_bw]),
      .out  (out[k*psum_bw +: psum_bw]),
      .empty(empty_vec[k]),
      .full (full_vec[k])
    );
  end

`ifdef OFIFO_OVERFLOW_FLAG_EN
  logic [col-1:0] dropped;

  assign dropped = wr & full_vec & ~{col{pop}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overflow <= 1'b0;
    end else if (|dropped) begin
      o_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ofifo.sv
// Directed scoreboard bench for ofifo; per-column queues model the expected heads.
module tb_ofifo;
  import ofifo_pkg::*;

  localparam int C = 8;
  localparam int W = 16;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [C*W-1:0] in = '0;
  logic [C-1:0]   wr = '0;
  logic           rd = 1'b0;
  logic [C*W-1:0] out;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
`ifdef OFIFO_OVERFLOW_FLAG_EN
  logic           o_overflow;
`endif
  logic           expOverflow = 1'b0;

  logic [W-1:0] model [C][$];
  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  ofifo #(.col(C), .psum_bw(W), .depth(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .wr        (wr),
    .rd        (rd),
    .out       (out),
    .o_valid   (o_valid),
    .o_full    (o_full),
`ifdef OFIFO_OVERFLOW_FLAG_EN
    .o_overflow(o_overflow),
`endif
    .o_ready   (o_ready)
  );

  function automatic logic [C*W-1:0] makeRow(input logic [W-1:0] base);
    logic [C*W-1:0] row;
    for (int k = 0; k < C; k++) row[k*W +: W] = base + W'(k * 16'h0100);
    return row;
  endfunction

  task automatic checkOutput(input string tag);
    logic expValid;
    logic expFull;
    expValid = 1'b1;
    expFull  = 1'b0;
    for (int k = 0; k < C; k++) begin
      if (model[k].size() == 0) expValid = 1'b0;
      if (model[k].size() == D) expFull = 1'b1;
    end
    testCount++;
    assert (o_valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s o_valid observed=%b expected=%b", tag, o_valid, expValid);
    end
    testCount++;
    assert (o_full === expFull) else begin
      failCount++;
      $error("[TB] FAIL %s o_full observed=%b expected=%b", tag, o_full, expFull);
    end
    testCount++;
    assert (o_ready === !expFull) else begin
      failCount++;
      $error("[TB] FAIL %s o_ready observed=%b expected=%b", tag, o_ready, !expFull);
    end
    if (expValid) begin
      for (int k = 0; k < C; k++) begin
        testCount++;
        assert (out[k*W +: W] === model[k][0]) else begin
          failCount++;
          $error("[TB] FAIL %s out col%0d observed=%h expected=%h", tag, k, out[k*W +: W], model[k][0]);
        end
      end
    end
`ifdef OFIFO_OVERFLOW_FLAG_EN
    testCount++;
    assert (o_overflow === expOverflow) else begin
      failCount++;
      $error("[TB] FAIL %s o_overflow observed=%b expected=%b", tag, o_overflow, expOverflow);
    end
`endif
  endtask

  // Drives one cycle of stimulus from a negedge, updates the model at the posedge, checks at the next negedge.
  task automatic applyStimulus(input logic [C-1:0] w, input logic [C*W-1:0] d, input logic r, input string tag);
    logic           validNow;
    logic           pop;
    logic [C-1:0]   fullNow;
    wr = w;
    in = d;
    rd = r;
    validNow = 1'b1;
    for (int k = 0; k < C; k++) begin
      if (model[k].size() == 0) validNow = 1'b0;
      fullNow[k] = (model[k].size() == D);
    end
    pop = r && validNow;
    @(posedge clk);
    for (int k = 0; k < C; k++) begin
      if (pop) void'(model[k].pop_front());
      if (w[k]) begin
        if (!fullNow[k] || pop) model[k].push_back(d[k*W +: W]);
        else expOverflow = 1'b1;
      end
    end
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic doReset();
    reset = 1'b0;
    wr    = '1;
    in    = makeRow(16'h00EE);
    rd    = 1'b0;
    for (int k = 0; k < C; k++) model[k].delete();
    expOverflow = 1'b0;
    #1;
    checkOutput("rstAssert");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstHeld");
    wr    = '0;
    reset = 1'b1;
  endtask

  initial begin
    logic [C*W-1:0] rowData;
    $display("[TB] starting ofifo bench");

    // Reset with writes held, then prove nothing was stored.
    @(negedge clk);
    doReset();
    applyStimulus('0, '0, 1'b0, "postRstIdle");
    applyStimulus('1, makeRow(16'h0055), 1'b0, "postRstWrite");
    applyStimulus('0, '0, 1'b1, "postRstPop");

    // Four full rows, then continuous popping.
    for (int v = 1; v <= 4; v++) applyStimulus('1, makeRow(W'(v)), 1'b0, "rowWrite");
    for (int v = 1; v <= 4; v++) applyStimulus('0, '0, 1'b1, "rowPop");
    applyStimulus('0, '0, 1'b1, "popWhenEmpty");

    // Staggered column writes: valid only once the last column lands.
    for (int t = 0; t < C; t++) applyStimulus(C'(1 << t), makeRow(W'(16'h00A0 + t)), 1'b0, "stagger");
    applyStimulus('0, '0, 1'b1, "staggerPop");

    // Fill column 3, overflow it, then write while popping.
    for (int i = 0; i < D; i++) applyStimulus(8'h08, makeRow(W'(16'h0030 + i)), 1'b0, "fillCol3");
    applyStimulus(8'h08, makeRow(16'h0BAD), 1'b0, "dropWrite");
    applyStimulus(~8'h08, makeRow(16'h0070), 1'b0, "fillOthers");
    applyStimulus(8'h08, makeRow(16'h0C0D), 1'b1, "writeWithPop");

    @(negedge clk);
    doReset();

    // Streaming write/pop pairs across the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < C; k++) rowData[k*W +: W] = W'($urandom_range(0, 65535));
      applyStimulus('1, rowData, 1'b1, "stream");
    end
    applyStimulus('0, '0, 1'b1, "streamDrain");

    // Asynchronous reset mid-burst with five rows stored.
    for (int v = 0; v < 5; v++) applyStimulus('1, makeRow(W'(16'h0090 + v)), 1'b0, "burst");
    wr = '1;
    in = makeRow(16'h00F0);
    #2;
    reset = 1'b0;
    for (int k = 0; k < C; k++) model[k].delete();
    expOverflow = 1'b0;
    #1;
    checkOutput("asyncRst");
    wr = '0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus('0, '0, 1'b1, "afterAsyncRst");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
